// File: rtl/tone_sequencer_if.sv
// Control, ROM and Audio_Controller signals of tone_sequencer.
// The sequencer connects through the slave modport; its driver connects through the master modport.
interface tone_sequencer_if #(
   parameter int DELAY_W = 19,
   parameter int ADDR_W  = 10
);
   logic               start;
   logic               stop;
   logic               loop;
   logic [ADDR_W-1:0]  rom_addr;
   logic [DELAY_W-1:0] rom_q;
   logic               audio_out_allowed;
   logic               audio_in_available;
   logic [31:0]        left_channel_audio_in;
   logic               read_audio_in;
   logic               write_audio_out;
   logic [31:0]        left_channel_audio_out;
   logic [31:0]        right_channel_audio_out;
   logic               busy;
   logic               done;

   modport master (
      output start, stop, loop, rom_q, audio_out_allowed, audio_in_available,
             left_channel_audio_in,
      input  rom_addr, read_audio_in, write_audio_out, left_channel_audio_out,
             right_channel_audio_out, busy, done
   );

   modport slave (
      input  start, stop, loop, rom_q, audio_out_allowed, audio_in_available,
             left_channel_audio_in,
      output rom_addr, read_audio_in, write_audio_out, left_channel_audio_out,
             right_channel_audio_out, busy, done
   );
endinterface

// File: rtl/tone_sequencer.sv
// ROM-driven square-wave melody player feeding Audio_Controller.
// Define TONE_SEQUENCER_MIX_MIC_EN to add the microphone sample to the tone.
module tone_sequencer #(
   parameter int DELAY_W     = 19,
   parameter int ADDR_W      = 10,
   parameter int SONG_LEN    = 1000,
   parameter int BEAT_CYCLES = 2500000,
   parameter int AMPLITUDE   = 100000000,
   parameter int ROM_LAT     = 2
) (
   input logic               CLOCK_50,
   input logic               resetn,
   tone_sequencer_if.slave   bus
);
   localparam int BEAT_W  = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam int FETCH_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BEAT_CYCLES - 1);
   localparam logic [FETCH_W-1:0] FETCH_LAST = FETCH_W'(ROM_LAT - 1);
   localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(SONG_LEN - 1);
   localparam logic [31:0]        AMP_POS    = 32'(AMPLITUDE);
   localparam logic [31:0]        AMP_NEG    = 32'd0 - 32'(AMPLITUDE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PLAY  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             r_state;
   logic [ADDR_W-1:0]  r_rom_addr;
   logic [FETCH_W-1:0] r_fetch_cnt;
   logic [DELAY_W-1:0] r_note;
   logic [DELAY_W-1:0] r_half_cnt;
   logic [BEAT_W-1:0]  r_beat_cnt;
   logic               r_phase;
   logic               r_loop;
   logic               r_busy;
   logic               r_done;
   logic [31:0]        r_sample;
   logic [31:0]        w_tone;

   // Tone value for the next sample; a stop forces silence on the same edge.
   always_comb begin
      if (bus.stop) begin
         w_tone = 32'd0;
      end else if ((r_state == S_PLAY) && (r_note != '0)) begin
         w_tone = r_phase ? AMP_POS : AMP_NEG;
      end else begin
         w_tone = 32'd0;
      end
   end

   // Sequencer FSM with its counters and registered outputs.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_rom_addr  <= '0;
         r_fetch_cnt <= '0;
         r_note      <= '0;
         r_half_cnt  <= '0;
         r_beat_cnt  <= '0;
         r_phase     <= 1'b0;
         r_loop      <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_sample    <= 32'd0;
      end else begin
         r_done <= 1'b0;
`ifdef TONE_SEQUENCER_MIX_MIC_EN
         r_sample <= bus.left_channel_audio_in + w_tone;
`else
         r_sample <= w_tone;
`endif
         if (bus.stop) begin
            r_state     <= S_IDLE;
            r_rom_addr  <= '0;
            r_fetch_cnt <= '0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
         end else if (bus.start) begin
            r_state     <= S_FETCH;
            r_rom_addr  <= '0;
            r_fetch_cnt <= '0;
            r_loop      <= bus.loop;
            r_busy      <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_busy <= 1'b0;
               end
               S_FETCH: begin
                  if (r_fetch_cnt == FETCH_LAST) begin
                     r_note     <= bus.rom_q;
                     r_half_cnt <= '0;
                     r_beat_cnt <= '0;
                     r_phase    <= 1'b0;
                     r_state    <= S_PLAY;
                  end else begin
                     r_fetch_cnt <= r_fetch_cnt + FETCH_W'(1);
                  end
               end
               S_PLAY: begin
                  // A zero note is a rest: the half-period counter runs but never toggles.
                  if ((r_note != '0) && (r_half_cnt == r_note)) begin
                     r_half_cnt <= '0;
                     r_phase    <= ~r_phase;
                  end else begin
                     r_half_cnt <= r_half_cnt + DELAY_W'(1);
                  end
                  if (r_beat_cnt == BEAT_LAST) begin
                     r_beat_cnt  <= '0;
                     r_fetch_cnt <= '0;
                     if (r_rom_addr < ADDR_LAST) begin
                        r_rom_addr <= r_rom_addr + ADDR_W'(1);
                        r_state    <= S_FETCH;
                     end else if (r_loop) begin
                        r_rom_addr <= '0;
                        r_state    <= S_FETCH;
                     end else begin
                        r_rom_addr <= '0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                     end
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.rom_addr                = r_rom_addr;
   assign bus.busy                    = r_busy;
   assign bus.done                    = r_done;
   assign bus.left_channel_audio_out  = r_sample;
   assign bus.right_channel_audio_out = r_sample;

`ifdef TONE_SEQUENCER_MIX_MIC_EN
   assign bus.read_audio_in   = bus.audio_in_available & bus.audio_out_allowed;
   assign bus.write_audio_out = bus.audio_in_available & bus.audio_out_allowed & r_busy;
`else
   logic w_unused_mic;
   assign w_unused_mic        = ^{bus.left_channel_audio_in, bus.audio_in_available};
   assign bus.read_audio_in   = 1'b0;
   assign bus.write_audio_out = bus.audio_out_allowed & r_busy;
`endif
endmodule
